// File: rtl/mlp_host_loader.sv
`default_nettype none
// ============================================================================
// mlp_host_loader : byte-stream command parser feeding the MLP input/weight/
//   bias BRAM write ports and streaming back the output BRAM.
// Build option: MLP_LOADER_BOUNDS_CHK_EN (per-target address limit checks)
// Rev 1.0
// ============================================================================
module mlp_host_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic [ADDR_W-1:0] input_addr,
    output logic [7:0]        input_data,
    output logic              input_we,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [7:0]        weight_data,
    output logic              weight_we,
    output logic [ADDR_W-1:0] bias_addr,
    output logic [7:0]        bias_data,
    output logic              bias_we,
    output logic [ADDR_W-1:0] output_rd_addr,
    input  logic [7:0]        output_rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ALO        = 4'd1,
        S_AHI        = 4'd2,
        S_LLO        = 4'd3,
        S_LHI        = 4'd4,
        S_WRITE      = 4'd5,
        S_RD_ADDR    = 4'd6,
        S_RD_WAIT    = 4'd7,
        S_RD_PRESENT = 4'd8,
        S_DONE       = 4'd9
    } state_t;

    localparam logic [1:0] C_OP_INPUT  = 2'd0;
    localparam logic [1:0] C_OP_WEIGHT = 2'd1;
    localparam logic [1:0] C_OP_BIAS   = 2'd2;
    localparam logic [1:0] C_OP_READ   = 2'd3;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remain;   // bytes left minus one, straight from LEN
    logic              w_s_acc;
    logic              w_m_acc;
    logic              w_in_bounds;

    assign w_s_acc = s_valid && s_ready;
    assign w_m_acc = m_valid && m_ready;

`ifdef MLP_LOADER_BOUNDS_CHK_EN
    logic [ADDR_W-1:0] w_limit;

    always_comb begin
        w_limit = ADDR_W'(4096);
        case (r_op)
            C_OP_INPUT:  w_limit = ADDR_W'(4096);
            C_OP_WEIGHT: w_limit = ADDR_W'(16384);
            C_OP_BIAS:   w_limit = ADDR_W'(256);
            default:     w_limit = ADDR_W'(4096);
        endcase
        w_in_bounds = (r_addr < w_limit);
    end

    // Sticky: any out-of-range write or readout byte latches the flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (!w_in_bounds &&
                     ((r_state == S_WRITE && w_s_acc) || r_state == S_RD_WAIT)) begin
            err <= 1'b1;
        end
    end
`else
    assign w_in_bounds = 1'b1;
    assign err         = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_s_acc) w_next = S_ALO;
            S_ALO:        if (w_s_acc) w_next = S_AHI;
            S_AHI:        if (w_s_acc) w_next = S_LLO;
            S_LLO:        if (w_s_acc) w_next = S_LHI;
            S_LHI:        if (w_s_acc) w_next = (r_op == C_OP_READ) ? S_RD_ADDR : S_WRITE;
            S_WRITE:      if (w_s_acc && r_remain == '0) w_next = S_DONE;
            S_RD_ADDR:    w_next = S_RD_WAIT;
            S_RD_WAIT:    w_next = S_RD_PRESENT;
            S_RD_PRESENT: if (w_m_acc) w_next = (r_remain == '0) ? S_DONE : S_RD_ADDR;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Every output is a flop; handshake/status flags are decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_op           <= 2'd0;
            r_addr         <= '0;
            r_remain       <= '0;
            s_ready        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            m_valid        <= 1'b0;
            m_data         <= 8'h00;
            input_addr     <= '0;
            input_data     <= 8'h00;
            input_we       <= 1'b0;
            weight_addr    <= '0;
            weight_data    <= 8'h00;
            weight_we      <= 1'b0;
            bias_addr      <= '0;
            bias_data      <= 8'h00;
            bias_we        <= 1'b0;
            output_rd_addr <= '0;
        end else begin
            r_state   <= w_next;
            s_ready   <= (w_next inside {S_IDLE, S_ALO, S_AHI, S_LLO, S_LHI, S_WRITE});
            busy      <= (w_next != S_IDLE);
            done      <= (w_next == S_DONE);
            input_we  <= 1'b0;
            weight_we <= 1'b0;
            bias_we   <= 1'b0;

            case (r_state)
                S_IDLE: if (w_s_acc) r_op <= s_data[1:0];
                S_ALO:  if (w_s_acc) r_addr[7:0] <= s_data;
                S_AHI:  if (w_s_acc) r_addr[ADDR_W-1:8] <= s_data;
                S_LLO:  if (w_s_acc) r_remain[7:0] <= s_data;
                S_LHI: begin
                    if (w_s_acc) begin
                        r_remain[ADDR_W-1:8] <= s_data;
                        output_rd_addr       <= r_addr;
                    end
                end
                S_WRITE: begin
                    if (w_s_acc) begin
                        case (r_op)
                            C_OP_INPUT: begin
                                input_addr <= r_addr;
                                input_data <= s_data;
                                input_we   <= w_in_bounds;
                            end
                            C_OP_WEIGHT: begin
                                weight_addr <= r_addr;
                                weight_data <= s_data;
                                weight_we   <= w_in_bounds;
                            end
                            default: begin
                                bias_addr <= r_addr;
                                bias_data <= s_data;
                                bias_we   <= w_in_bounds;
                            end
                        endcase
                        r_addr   <= r_addr + 1'b1;
                        r_remain <= r_remain - 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    // BRAM data for output_rd_addr is valid during this cycle
                    m_data  <= w_in_bounds ? output_rd_data : 8'h00;
                    m_valid <= 1'b1;
                end
                S_RD_PRESENT: begin
                    if (w_m_acc) begin
                        m_valid        <= 1'b0;
                        r_addr         <= r_addr + 1'b1;
                        output_rd_addr <= r_addr + 1'b1;
                        r_remain       <= r_remain - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_host_loader.sv
`default_nettype none
// ============================================================================
// tb_mlp_host_loader : table vectors, directed corner sequences and random
//   frames checked against a queue-based model of the command protocol.
// Rev 1.0
// ============================================================================
module tb_mlp_host_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [15:0] input_addr, weight_addr, bias_addr, output_rd_addr;
    logic [7:0]  input_data, weight_data, bias_data;
    logic        input_we, weight_we, bias_we;
    logic [7:0]  rd_q;
    logic        busy, done, err;

    always #5 clk = ~clk;

    mlp_host_loader #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .input_addr(input_addr), .input_data(input_data), .input_we(input_we),
        .weight_addr(weight_addr), .weight_data(weight_data), .weight_we(weight_we),
        .bias_addr(bias_addr), .bias_data(bias_data), .bias_we(bias_we),
        .output_rd_addr(output_rd_addr), .output_rd_data(rd_q),
        .busy(busy), .done(done), .err(err)
    );

    // Output BRAM: synchronous read, one cycle latency
    logic [7:0] out_mem [0:65535];
    always @(posedge clk) rd_q <= out_mem[output_rd_addr];

    typedef struct packed {
        logic [1:0]  port;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t obs_q[$];
    int  done_cnt = 0;

    always @(negedge clk) begin
        if (input_we)  obs_q.push_back({2'd0, input_addr,  input_data});
        if (weight_we) obs_q.push_back({2'd1, weight_addr, weight_data});
        if (bias_we)   obs_q.push_back({2'd2, bias_addr,   bias_data});
        if (done)      done_cnt <= done_cnt + 1;
    end

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] pay_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("s_ready_wait", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_header(input logic [7:0] op, input logic [15:0] addr, input int n);
        logic [15:0] len;
        len = 16'(n - 1);
        send_byte(op, 0);
        send_byte(addr[7:0], 0);
        send_byte(addr[15:8], 0);
        send_byte(len[7:0], 0);
        send_byte(len[15:8], 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    // Sends a write frame from pay_q and checks the writes against the model
    task automatic run_write(input string tag, input logic [7:0] op, input logic [15:0] addr, input int gap);
        int   base, d0, n;
        wr_t  exp_w;
        base = obs_q.size();
        d0   = done_cnt;
        n    = pay_q.size();
        send_header(op, addr, n);
        for (int i = 0; i < n; i++) send_byte(pay_q[i], gap);
        @(negedge clk);
        s_valid = 1'b0;
        wait_idle();
        check({tag, "_wr_count"}, 32'(obs_q.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < obs_q.size(); i++) begin
            exp_w.port = op[1:0];
            exp_w.addr = addr + 16'(i);
            exp_w.data = pay_q[i];
            check($sformatf("%s_wr%0d", tag, i), 32'(obs_q[base + i]), 32'(exp_w));
        end
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic recv_byte(input int stall, output logic [7:0] b, output bit stable, output bit dropped);
        int t;
        t = 0;
        @(negedge clk);
        while (!m_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("m_valid_wait", {31'd0, m_valid}, 32'd1);
        b      = m_data;
        stable = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (!m_valid || m_data !== b) stable = 1'b0;
        end
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        dropped = !m_valid;
    endtask

    task automatic run_read(input string tag, input logic [7:0] op, input logic [15:0] addr, input int n, input int stall_max);
        int         base, d0, stall;
        logic [7:0] b;
        bit         stable, dropped;
        base = obs_q.size();
        d0   = done_cnt;
        send_header(op, addr, n);
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            stall = $urandom_range(stall_max, 0);
            recv_byte(stall, b, stable, dropped);
            check($sformatf("%s_rd%0d", tag, i), 32'(b), 32'(out_mem[addr + 16'(i)]));
            check($sformatf("%s_drop%0d", tag, i), {31'd0, dropped}, 32'd1);
            if (stall > 0) check($sformatf("%s_hold%0d", tag, i), {31'd0, stable}, 32'd1);
        end
        wait_idle();
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_no_writes"}, 32'(obs_q.size() - base), 32'd0);
    endtask

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] addr;
        logic [2:0]  n;
        logic [31:0] pay;
        logic [1:0]  gap;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t vt[4];

    initial begin
        int         base, d0;
        logic [7:0] b;
        bit         stable, dropped;
        logic [7:0] op;
        logic [15:0] addr;
        int         n;

        for (int i = 0; i < 65536; i++) out_mem[i] = 8'($urandom);

        vt[0] = '{op: 8'h00, addr: 16'h0010, n: 3'd3, pay: 32'h00CC_BBAA, gap: 2'd0,
                  exp_addr: 64'h0000_0012_0011_0010};
        vt[1] = '{op: 8'h01, addr: 16'hFFFF, n: 3'd2, pay: 32'h0000_2211, gap: 2'd0,
                  exp_addr: 64'h0000_0000_0000_FFFF};
        vt[2] = '{op: 8'hFE, addr: 16'h1234, n: 3'd1, pay: 32'h0000_005A, gap: 2'd0,
                  exp_addr: 64'h0000_0000_0000_1234};
        vt[3] = '{op: 8'h00, addr: 16'h0200, n: 3'd4, pay: 32'h4433_2211, gap: 2'd1,
                  exp_addr: 64'h0203_0202_0201_0200};

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        check("rst_outputs", {19'd0, s_ready, busy, done, m_valid, input_we, weight_we,
                              bias_we, err, (|input_addr), (|output_rd_addr), (|m_data), (|bias_addr), (|weight_addr)},
              32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_s_ready", {30'd0, s_ready, busy}, 32'd2);

        // Table vectors: literal expected write addresses
        for (int v = 0; v < 4; v++) begin
            base = obs_q.size();
            d0   = done_cnt;
            send_header(vt[v].op, vt[v].addr, int'(vt[v].n));
            for (int i = 0; i < int'(vt[v].n); i++) send_byte(vt[v].pay[8*i +: 8], int'(vt[v].gap));
            @(negedge clk);
            s_valid = 1'b0;
            wait_idle();
            check($sformatf("vec%0d_count", v), 32'(obs_q.size() - base), 32'(vt[v].n));
            for (int i = 0; i < int'(vt[v].n) && base + i < obs_q.size(); i++)
                check($sformatf("vec%0d_wr%0d", v, i), 32'(obs_q[base + i]),
                      32'({vt[v].op[1:0], vt[v].exp_addr[16*i +: 16], vt[v].pay[8*i +: 8]}));
            check($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'd1);
        end

        // Readout with 4-cycle consumer stall on the first byte
        out_mem[5] = 8'h7E;
        out_mem[6] = 8'h81;
        d0 = done_cnt;
        send_header(8'h03, 16'h0005, 2);
        @(negedge clk);
        s_valid = 1'b0;
        recv_byte(4, b, stable, dropped);
        check("rd3_byte0", 32'(b), 32'h7E);
        check("rd3_hold", {31'd0, stable}, 32'd1);
        check("rd3_no_early_done", 32'(done_cnt - d0), 32'd0);
        recv_byte(0, b, stable, dropped);
        check("rd3_byte1", 32'(b), 32'h81);
        wait_idle();
        check("rd3_done", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset after 2 of 4 payload bytes
        base = obs_q.size();
        send_header(8'h00, 16'h0100, 4);
        send_byte(8'hD1, 0);
        send_byte(8'hD2, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async", {27'd0, s_ready, busy, input_we, (|input_addr), (|input_data)}, 32'd0);
        check("rst_partial_writes", 32'(obs_q.size() - base), 32'd2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pay_q = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        run_write("post_rst", 8'h02, 16'h0040, 0);

        // Random frames against the model
        for (int f = 0; f < 14; f++) begin
            op   = {6'($urandom), 2'($urandom_range(3, 0))};
            addr = ($urandom_range(1, 0) == 1) ? 16'($urandom) : 16'hFFFD + 16'($urandom_range(4, 0));
            n    = $urandom_range(6, 1);
            if (op[1:0] == 2'd3) begin
                run_read($sformatf("rnd%0d", f), op, addr, n, 3);
            end else begin
                pay_q.delete();
                for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
                run_write($sformatf("rnd%0d", f), op, addr, $urandom_range(2, 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
